// File: rtl/x4xx_qsfp_mux_pkg.sv
// x4xx_qsfp_mux_pkg
// Shared types for the four-lane QSFP CHDR packet mux: lane count, lane
// index type, arbiter FSM states and the round-robin pick helper.
package x4xx_qsfp_mux_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  // Index of one QSFP lane (0..3)
  typedef logic [LANE_W-1:0] lane_idx_t;

  // IDLE: looking for a lane to grant
  // PASS: forwarding the granted lane's packet
  // DROP: discarding the tail of an oversize packet up to its real tlast
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } mux_state_t;

  // Result of a round-robin search
  typedef struct packed {
    logic      found;
    lane_idx_t idx;
  } rr_pick_t;

  // First requesting lane, searching upward from (last + 1) mod NUM_LANES.
  // The last lane checked is 'last' itself, so a lone requester is still
  // granted back to back.
  function automatic rr_pick_t rr_pick(input logic [NUM_LANES-1:0] req,
                                       input lane_idx_t            last);
    rr_pick_t  res;
    lane_idx_t cand;
    res = '0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = last + lane_idx_t'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/x4xx_qsfp_mux_out_reg.sv
// x4xx_qsfp_mux_out_reg
// Two-entry skid register slice. A main register drives the output; a skid
// register catches the one beat that can arrive in the cycle the downstream
// stalls. in_ready comes from a flop only, so the upstream ready path never
// sees out_ready combinationally. One cycle of latency, full throughput.
module x4xx_qsfp_mux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_fire;

  assign in_ready  = ~skid_valid_q;
  assign out_data  = main_data_q;
  assign out_valid = main_valid_q;

  // Next-state: refill the main register when it is empty or draining,
  // otherwise park an accepted beat in the skid register.
  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    in_fire      = in_valid & ~skid_valid_q;

    if (out_ready || !main_valid_q) begin
      if (skid_valid_q) begin
        // in_ready was low, so nothing new arrives this cycle
        main_data_d  = skid_data_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) begin
          main_data_d = in_data;
        end
      end
    end else if (in_fire) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/x4xx_qsfp_chdr_mux.sv
// x4xx_qsfp_chdr_mux
// Merges the four per-lane CHDR streams from the QSFP wrapper into one
// stream for the router. Packet-granular round-robin arbitration, one idle
// cycle between packets, registered output through a skid slice, and
// oversize-packet truncation (forced tlast, tail dropped, err_oversize pulse).
// Optional feature: define QSFP_MUX_PKT_CNT_EN to add the pkt_cnt output
// (per-lane 32-bit forwarded-packet counters, lane i at [i*32 +: 32]).
module x4xx_qsfp_chdr_mux
  import x4xx_qsfp_mux_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int MTU_W  = 10
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst_n,
  input  logic [NUM_LANES*CHDR_W-1:0]   s_tdata,
  input  logic [NUM_LANES-1:0]          s_tlast,
  input  logic [NUM_LANES-1:0]          s_tvalid,
  output logic [NUM_LANES-1:0]          s_tready,
  output logic [CHDR_W-1:0]             m_tdata,
  output logic                          m_tlast,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [LANE_W-1:0]             m_tuser,
  input  logic [NUM_LANES-1:0]          lane_en,
  output logic                          err_oversize
`ifdef QSFP_MUX_PKT_CNT_EN
  ,
  output logic [NUM_LANES*32-1:0]       pkt_cnt
`endif
);

  localparam int OUT_W = CHDR_W + 1 + LANE_W;
  // Packet length limit in beats, and the counter increment
  localparam logic [MTU_W:0] MAX_BEATS = {1'b1, {MTU_W{1'b0}}};
  localparam logic [MTU_W:0] CNT_ONE   = {{MTU_W{1'b0}}, 1'b1};

  // Lane data split into an array so the granted lane is a plain index
  logic [CHDR_W-1:0] lane_data [NUM_LANES];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_split
      assign lane_data[gi] = s_tdata[gi*CHDR_W +: CHDR_W];
    end
  endgenerate

  mux_state_t        state_q, state_d;
  // Lane being served in PASS/DROP; also the round-robin pointer
  lane_idx_t         last_grant_q, last_grant_d;
  logic [MTU_W:0]    beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;

  logic              sel_valid;
  logic              sel_last;
  logic [CHDR_W-1:0] sel_data;
  logic              at_limit;
  logic              pass_fire;
  rr_pick_t          pick;

  logic              skid_in_valid;
  logic              skid_in_ready;
  logic              skid_in_last;
  logic [OUT_W-1:0]  skid_in;
  logic [OUT_W-1:0]  skid_out;

  // Arbiter FSM next-state, lane readies and the beat handed to the slice
  always_comb begin
    sel_valid     = s_tvalid[last_grant_q];
    sel_last      = s_tlast[last_grant_q];
    sel_data      = lane_data[last_grant_q];
    pick          = rr_pick(s_tvalid & lane_en, last_grant_q);
    at_limit      = ((beat_cnt_q + CNT_ONE) == MAX_BEATS);

    state_d       = state_q;
    last_grant_d  = last_grant_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = 1'b0;
    s_tready      = '0;
    skid_in_valid = 1'b0;
    pass_fire     = 1'b0;

    case (state_q)
      IDLE: begin
        // lane_en gates only new grants; a packet in flight always finishes
        if (pick.found) begin
          last_grant_d = pick.idx;
          beat_cnt_d   = '0;
          state_d      = PASS;
        end
      end

      PASS: begin
        s_tready[last_grant_q] = skid_in_ready;
        skid_in_valid          = sel_valid;
        pass_fire              = sel_valid & skid_in_ready;
        if (pass_fire) begin
          if (sel_last) begin
            beat_cnt_d = '0;
            state_d    = IDLE;
          end else if (at_limit) begin
            // This beat goes out with a forced tlast; the rest is discarded
            beat_cnt_d = '0;
            err_d      = 1'b1;
            state_d    = DROP;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end

      DROP: begin
        // Swallow beats until the source's own tlast
        s_tready[last_grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    skid_in_last = sel_last | at_limit;
    skid_in      = {skid_in_last, last_grant_q, sel_data};
  end

  // Arbiter state registers
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= lane_idx_t'(NUM_LANES - 1);
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  assign err_oversize = err_q;

  x4xx_qsfp_mux_out_reg #(
    .WIDTH (OUT_W)
  ) u_out_reg (
    .clk       (bus_clk),
    .rst_n     (bus_rst_n),
    .in_data   (skid_in),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign m_tlast = skid_out[OUT_W-1];
  assign m_tuser = skid_out[CHDR_W +: LANE_W];
  assign m_tdata = skid_out[CHDR_W-1:0];

`ifdef QSFP_MUX_PKT_CNT_EN
  // A packet counts when its final forwarded beat (real or forced tlast)
  // enters the output slice.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pkt_cnt
      logic [31:0] cnt_q, cnt_d;

      // Increment on this lane's packet-closing beat; wraps at 2^32
      always_comb begin
        cnt_d = cnt_q;
        if (pass_fire && skid_in_last && (last_grant_q == lane_idx_t'(gi))) begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      // Counter register
      always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign pkt_cnt[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`endif

endmodule
